// File: rtl/neopixel_pkg.sv
// Shared types and constants for the NeoPixel strand driver.
// Holds the FSM/phase enums, channel indices, byte order and default timings.
package neopixel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        LATCH
    } neo_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_HIGH,
        PH_LOW
    } bit_phase_e;

    localparam int RED   = 0;
    localparam int BLUE  = 1;
    localparam int GREEN = 2;
    localparam int WHITE = 3;

    localparam int unsigned DEF_T1H          = 35;
    localparam int unsigned DEF_T1L          = 30;
    localparam int unsigned DEF_T0H          = 18;
    localparam int unsigned DEF_T0L          = 40;
    localparam int unsigned DEF_LATCH_CYCLES = 2500;

    // Wire order within a pixel: G, R, B, then W.
    function automatic int slot_chan(input int slot);
        unique case (slot)
            0:       return GREEN;
            1:       return RED;
            2:       return BLUE;
            default: return WHITE;
        endcase
    endfunction

    function automatic int unsigned max2(input int unsigned a,
                                         input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/neo_bit_encoder.sv
// Single-bit waveform generator: HIGH then LOW phase with per-value lengths.
// A start on the bit_done cycle chains the next bit with no gap cycle.
module neo_bit_encoder
    import neopixel_pkg::*;
#(
    parameter int unsigned T1H = DEF_T1H,
    parameter int unsigned T1L = DEF_T1L,
    parameter int unsigned T0H = DEF_T0H,
    parameter int unsigned T0L = DEF_T0L,
    parameter int unsigned CW  = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic start_i,
    input  logic bit_i,
    output logic data_o,
    output logic hi_done_o,
    output logic bit_done_o
);

    localparam logic [CW-1:0] H1 = CW'(T1H - 1);
    localparam logic [CW-1:0] L1 = CW'(T1L - 1);
    localparam logic [CW-1:0] H0 = CW'(T0H - 1);
    localparam logic [CW-1:0] L0 = CW'(T0L - 1);

    bit_phase_e    phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          data_q;

    always_comb begin
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        hi_done_o  = 1'b0;
        bit_done_o = 1'b0;
        unique case (phase_q)
            PH_HIGH: begin
                if (cnt_q == (bit_i ? H1 : H0)) begin
                    phase_d   = PH_LOW;
                    cnt_d     = '0;
                    hi_done_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PH_LOW: begin
                if (cnt_q == (bit_i ? L1 : L0)) begin
                    bit_done_o = 1'b1;
                    cnt_d      = '0;
                    phase_d    = start_i ? PH_HIGH : PH_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (start_i) begin
                    phase_d = PH_HIGH;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            data_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            data_q  <= (phase_d == PH_HIGH);
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/neo_strand_driver.sv
// NeoPixel strand driver: double-buffered frame store serialised onto one wire.
// Shadow is host-written; active is a shift register loaded at frame start.
module neo_strand_driver
    import neopixel_pkg::*;
#(
    parameter int unsigned NUM_PIXELS   = 8,
    parameter int unsigned CHANNELS     = 3,
    parameter int unsigned T1H          = DEF_T1H,
    parameter int unsigned T1L          = DEF_T1L,
    parameter int unsigned T0H          = DEF_T0H,
    parameter int unsigned T0L          = DEF_T0L,
    parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES,
    localparam int unsigned PIW =
        (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load_color,
    input  logic [PIW-1:0] pixel_index,
    input  logic [1:0]     color_index,
    input  logic [7:0]     color_level,
    input  logic           clear_all,
    input  logic           send_it,
    input  logic           repeat_en,
    output logic           neo_data,
    output logic           ready_to_load,
    output logic           ready_to_send,
    output logic           begin_send,
    output logic           done_send,
    output logic           done_wait,
    output logic           load_err
);

    localparam int unsigned NBITS = NUM_PIXELS * CHANNELS * 8;
    localparam int unsigned BW    = $clog2(NBITS + 1);
    localparam int unsigned TMAX  =
        max2(max2(max2(T1H, T1L), max2(T0H, T0L)), LATCH_CYCLES);
    localparam int unsigned CW    = $clog2(TMAX + 1);

    localparam logic [BW-1:0] LAST_BIT   = BW'(NBITS - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);

    typedef logic [NUM_PIXELS-1:0][CHANNELS-1:0][7:0] frame_t;

    frame_t          shadow_q, shadow_d;
    logic [NBITS-1:0] active_q, active_d, serial_w;
    neo_state_e      state_q, state_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [CW-1:0]   lat_q, lat_d;
    logic            begin_q, begin_d;
    logic            done_send_q, done_send_d;
    logic            load_err_q, load_err_d;
    logic            load_ok, enc_start, hi_done, bit_done;

    assign load_ok = load_color
                   && (32'(pixel_index) < NUM_PIXELS)
                   && (32'(color_index) < CHANNELS);

    always_comb begin
        shadow_d   = shadow_q;
        load_err_d = load_color && !clear_all && !load_ok;
        if (clear_all) begin
            shadow_d = '0;
        end else if (load_ok) begin
            shadow_d[pixel_index][color_index] = color_level;
        end
    end

    // Flatten the shadow into wire order so bit 0 is the first bit sent.
    always_comb begin
        serial_w = '0;
        for (int p = 0; p < int'(NUM_PIXELS); p++) begin
            for (int s = 0; s < int'(CHANNELS); s++) begin
                for (int j = 0; j < 8; j++) begin
                    serial_w[(p * int'(CHANNELS) + s) * 8 + 7 - j] =
                        shadow_q[p][slot_chan(s)][j];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        lat_d       = lat_q;
        active_d    = active_q;
        enc_start   = 1'b0;
        begin_d     = 1'b0;
        done_send_d = 1'b0;
        done_wait   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (send_it) begin
                    state_d   = HIGH;
                    active_d  = serial_w;
                    bit_d     = '0;
                    enc_start = 1'b1;
                    begin_d   = 1'b1;
                end
            end
            HIGH: begin
                if (hi_done) state_d = LOW;
            end
            LOW: begin
                if (bit_done) begin
                    if (bit_q == LAST_BIT) begin
                        state_d     = LATCH;
                        lat_d       = '0;
                        done_send_d = 1'b1;
                    end else begin
                        state_d   = HIGH;
                        bit_d     = bit_q + 1'b1;
                        active_d  = active_q >> 1;
                        enc_start = 1'b1;
                    end
                end
            end
            LATCH: begin
                if (lat_q == LATCH_LAST) begin
                    done_wait = 1'b1;
                    if (repeat_en) begin
                        state_d   = HIGH;
                        active_d  = serial_w;
                        bit_d     = '0;
                        enc_start = 1'b1;
                        begin_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            active_q    <= '0;
            bit_q       <= '0;
            lat_q       <= '0;
            begin_q     <= 1'b0;
            done_send_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            bit_q       <= bit_d;
            lat_q       <= lat_d;
            begin_q     <= begin_d;
            done_send_q <= done_send_d;
            load_err_q  <= load_err_d;
        end
    end

    neo_bit_encoder #(
        .T1H (T1H),
        .T1L (T1L),
        .T0H (T0H),
        .T0L (T0L),
        .CW  (CW)
    ) u_enc (
        .clock      (clock),
        .reset      (reset),
        .start_i    (enc_start),
        .bit_i      (active_q[0]),
        .data_o     (neo_data),
        .hi_done_o  (hi_done),
        .bit_done_o (bit_done)
    );

    assign ready_to_load = 1'b1;
    assign ready_to_send = (state_q == IDLE);
    assign begin_send    = begin_q;
    assign done_send     = done_send_q;
    assign load_err      = load_err_q;

endmodule

// File: tb/tb_neo_strand_driver.sv
// Bench for neo_strand_driver: a frame-level waveform model checked every
// cycle, plus hand-computed timing and pulse-count expectations.
module tb_neo_strand_driver;

    localparam int NP  = 2;
    localparam int CH  = 3;
    localparam int T1H = 4;
    localparam int T1L = 3;
    localparam int T0H = 2;
    localparam int T0L = 5;
    localparam int LAT = 10;
    localparam int TRN = 8192;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load_color = 1'b0;
    logic [0:0] pixel_index = '0;
    logic [1:0] color_index = '0;
    logic [7:0] color_level = '0;
    logic       clear_all = 1'b0;
    logic       send_it = 1'b0;
    logic       repeat_en = 1'b0;
    logic neo_data, ready_to_load, ready_to_send;
    logic begin_send, done_send, done_wait, load_err;

    logic       load3 = 1'b0;
    logic [1:0] pix3 = '0;
    logic [1:0] col3 = '0;
    logic       zero = 1'b0;
    logic neo3, rtl3, rts3, beg3, ds3, dw3, err3;

    always #5 clock = ~clock;

    neo_strand_driver #(
        .NUM_PIXELS(NP), .CHANNELS(CH), .T1H(T1H), .T1L(T1L),
        .T0H(T0H), .T0L(T0L), .LATCH_CYCLES(LAT)
    ) dut (
        .clock(clock), .reset(reset), .load_color(load_color),
        .pixel_index(pixel_index), .color_index(color_index),
        .color_level(color_level), .clear_all(clear_all),
        .send_it(send_it), .repeat_en(repeat_en),
        .neo_data(neo_data), .ready_to_load(ready_to_load),
        .ready_to_send(ready_to_send), .begin_send(begin_send),
        .done_send(done_send), .done_wait(done_wait),
        .load_err(load_err)
    );

    // RGBW, 3-pixel instance: pixel_index is wide enough to go out of range.
    neo_strand_driver #(
        .NUM_PIXELS(3), .CHANNELS(4), .T1H(T1H), .T1L(T1L),
        .T0H(T0H), .T0L(T0L), .LATCH_CYCLES(LAT)
    ) dut3 (
        .clock(clock), .reset(reset), .load_color(load3),
        .pixel_index(pix3), .color_index(col3),
        .color_level(8'h5A), .clear_all(zero),
        .send_it(zero), .repeat_en(zero),
        .neo_data(neo3), .ready_to_load(rtl3),
        .ready_to_send(rts3), .begin_send(beg3),
        .done_send(ds3), .done_wait(dw3), .load_err(err3)
    );

    typedef struct packed {
        logic neo;
        logic beg;
        logic ds;
        logic dw;
        logic rts;
    } exp_t;

    localparam exp_t IDLE_E = exp_t'{neo: 1'b0, beg: 1'b0, ds: 1'b0,
                                     dw: 1'b0, rts: 1'b1};

    exp_t       q[$];
    exp_t       cur;
    logic       exp_err;
    logic [7:0] sh [NP][CH];
    logic       tr_neo [TRN];
    int cyc, nchk, nfail;
    int t_beg, t_ds, t_dw, n_beg, n_err;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nfail++;
            if (nfail <= 40)
                $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, a, e);
        end
    endtask

    // Expected per-cycle outputs of a whole frame built from the shadow.
    function automatic void push_frame();
        int order [3] = '{2, 0, 1};
        for (int b = 0; b < NP * CH * 8; b++) begin
            int   pix = b / (CH * 8);
            int   chn = order[(b / 8) % CH];
            logic v   = sh[pix][chn][7 - (b % 8)];
            int   hi  = v ? T1H : T0H;
            int   lo  = v ? T1L : T0L;
            for (int c = 0; c < hi + lo; c++)
                q.push_back(exp_t'{neo: (c < hi), beg: (b == 0 && c == 0),
                                   ds: 1'b0, dw: 1'b0, rts: 1'b0});
        end
        for (int c = 0; c < LAT; c++)
            q.push_back(exp_t'{neo: 1'b0, beg: 1'b0, ds: (c == 0),
                               dw: (c == LAT - 1), rts: 1'b0});
    endfunction

    function automatic int ones(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++)
            if (i >= 0 && i < TRN && tr_neo[i] === 1'b1) n++;
        return n;
    endfunction

    initial begin
        cur = IDLE_E;
        exp_err = 1'b0;
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
            if (reset) begin
                q.delete();
                cur = IDLE_E;
                exp_err = 1'b0;
                foreach (sh[p, c]) sh[p][c] = 8'h00;
            end else begin
                if (cur.dw && repeat_en) push_frame();
                if (cur.rts && send_it) push_frame();
                exp_err = load_color && !clear_all && !(color_index < CH);
                if (clear_all) begin
                    foreach (sh[p, c]) sh[p][c] = 8'h00;
                end else if (load_color && color_index < CH) begin
                    sh[pixel_index][color_index] = color_level;
                end
                cur = (q.size() != 0) ? q.pop_front() : IDLE_E;
            end
            #1;
            if (cyc < TRN) tr_neo[cyc] = neo_data;
            if (begin_send === 1'b1) begin t_beg = cyc; n_beg++; end
            if (done_send === 1'b1) t_ds = cyc;
            if (done_wait === 1'b1) t_dw = cyc;
            if (load_err === 1'b1) n_err++;
            chk("neo_data", neo_data, cur.neo);
            chk("begin_send", begin_send, cur.beg);
            chk("done_send", done_send, cur.ds);
            chk("done_wait", done_wait, cur.dw);
            chk("ready_to_send", ready_to_send, cur.rts);
            chk("ready_to_load", ready_to_load, 1'b1);
            chk("load_err", load_err, exp_err);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic load(input int p, input int c, input int v);
        load_color = 1'b1;
        pixel_index = 1'(p);
        color_index = 2'(c);
        color_level = 8'(v);
        @(negedge clock);
        load_color = 1'b0;
    endtask

    task automatic send(output int t0);
        send_it = 1'b1;
        t0 = cyc;
        @(negedge clock);
        send_it = 1'b0;
    endtask

    int t0, t1, nb0, e0, s;

    initial begin
        nchk = 0; nfail = 0; n_beg = 0; n_err = 0;
        t_beg = -1; t_ds = -1; t_dw = -1;
        tick(3);
        chk("rst_neo", neo_data, 1'b0);
        chk("rst_rts", ready_to_send, 1'b1);
        chk("rst_rtl", ready_to_load, 1'b1);
        chk("rst_beg", begin_send, 1'b0);
        chk("rst_ds", done_send, 1'b0);
        chk("rst_dw", done_wait, 1'b0);
        chk("rst_err", load_err, 1'b0);
        reset = 1'b0;
        tick(2);

        // Empty frame: 48 zero-bits of 2 high + 5 low.
        send(t0);
        tick(350);
        chk("t1_begin_at", t_beg - t0, 1);
        chk("t1_dsend_at", t_ds - t0, 337);
        chk("t1_dwait_at", t_dw - t0, 346);
        chk("t1_high_cycles", ones(t0 + 1, t0 + 347), 96);
        chk("t1_rts_after", ready_to_send, 1'b1);

        // G0=0x80, then load R1=0xFF while bit 0 is high.
        load(0, 2, 8'h80);
        send(t0);
        load(1, 0, 8'hFF);
        tick(350);
        chk("t2_bit0_high", ones(t0 + 1, t0 + 4), 4);
        chk("t2_bit0_low", ones(t0 + 5, t0 + 7), 0);
        chk("t2_bit1_high", ones(t0 + 8, t0 + 14), 2);
        chk("t2_bits32_39", ones(t0 + 225, t0 + 280), 16);
        chk("t2_frame_high", ones(t0 + 1, t0 + 347), 98);
        send(t1);
        tick(350);
        chk("t3_bits32_39", ones(t1 + 225, t1 + 280), 32);
        chk("t3_frame_high", ones(t1 + 1, t1 + 347), 114);

        // Illegal colour index on RGB; pixel range on the 3-pixel RGBW unit.
        e0 = n_err;
        load(1, 3, 8'h55);
        tick(1);
        chk("t4_err_count", n_err - e0, 1);
        load3 = 1'b1; pix3 = 2'd3; col3 = 2'd0;
        @(negedge clock);
        load3 = 1'b0;
        chk("t4_pix_err", err3, 1'b1);
        tick(1);
        chk("t4_pix_err_gone", err3, 1'b0);
        load3 = 1'b1; pix3 = 2'd2; col3 = 2'd3;
        @(negedge clock);
        load3 = 1'b0;
        chk("t4_white_ok", err3, 1'b0);
        send(t0);
        tick(350);
        chk("t4_frame_high", ones(t0 + 1, t0 + 347), 114);

        // Auto-repeat with B1=0x0F loaded during the latch gap.
        nb0 = n_beg;
        repeat_en = 1'b1;
        send(t0);
        tick(340);
        load(1, 1, 8'h0F);
        tick(10);
        repeat_en = 1'b0;
        tick(350);
        s = t0 + 347;
        chk("t5_begin_count", n_beg - nb0, 2);
        chk("t5_rebegin_at", t_beg - t0, 347);
        chk("t5_bits40_47", ones(s + 280, s + 335), 24);
        chk("t5_frame2_high", ones(s, s + 345), 122);
        chk("t5_rts_after", ready_to_send, 1'b1);

        // Reset mid-HIGH, then clear_all beating a same-cycle load.
        send(t0);
        chk("t6_high_before", neo_data, 1'b1);
        reset = 1'b1;
        #1;
        chk("t6_async_low", neo_data, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(2);
        send(t0);
        tick(350);
        chk("t6_cleared_frame", ones(t0 + 1, t0 + 347), 96);
        load(0, 2, 8'hAA);
        e0 = n_err;
        clear_all = 1'b1;
        load(0, 0, 8'h33);
        clear_all = 1'b0;
        tick(1);
        chk("t6_clear_no_err", n_err - e0, 0);
        send(t0);
        tick(350);
        chk("t6_clear_frame", ones(t0 + 1, t0 + 347), 96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
